// File: rtl/instr_fifo_dispatch.sv
// Two independent show-ahead instruction queues feeding two valid/ready execution lanes.
// Define DISPATCH_STATS_EN to add occupancy high-water marks and per-lane stall counters.
module instr_fifo_dispatch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_in,
  input  logic             fifo1_en,
  input  logic             fifo2_en,
  output logic             fifo1_full,
  output logic             fifo2_full,
  output logic [WIDTH-1:0] lane1_instr,
  output logic             lane1_valid,
  input  logic             lane1_ready,
  output logic [WIDTH-1:0] lane2_instr,
  output logic             lane2_valid,
  input  logic             lane2_ready,
  output logic [CNT_W-1:0] fifo1_count,
  output logic [CNT_W-1:0] fifo2_count,
`ifdef DISPATCH_STATS_EN
  output logic [CNT_W-1:0] hwm1,
  output logic [CNT_W-1:0] hwm2,
  output logic [15:0]      stall1,
  output logic [15:0]      stall2,
`endif
  output logic             err_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [CNT_W-1:0] count_q  [2];
  logic [WIDTH-1:0] head     [2];
  logic             err_ovf_q;

  logic [1:0] en;
  logic [1:0] rdy;
  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic       both_en;
  logic       ovf_set;

  always_comb begin
    en      = {fifo2_en, fifo1_en};
    rdy     = {lane2_ready, lane1_ready};
    both_en = fifo1_en & fifo2_en;
    full    = '0;
    valid   = '0;
    push    = '0;
    pop     = '0;
    for (int q = 0; q < 2; q++) begin
      full[q]  = (count_q[q] == CNT_W'(DEPTH));
      valid[q] = (count_q[q] != '0);
      // A push into a full queue is rejected even if that queue pops this cycle.
      push[q]  = en[q] & ~both_en & ~full[q];
      pop[q]   = valid[q] & rdy[q];
      head[q]  = valid[q] ? mem_q[q][rd_ptr_q[q]] : '0;
    end
    ovf_set = both_en | (fifo1_en & full[0]) | (fifo2_en & full[1]);
  end

  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (push[q]) mem_q[q][wr_ptr_q[q]] <= instr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        count_q[q]  <= '0;
      end
      err_ovf_q <= 1'b0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push[q]) wr_ptr_q[q] <= wr_ptr_q[q] + PTR_W'(1);
        if (pop[q])  rd_ptr_q[q] <= rd_ptr_q[q] + PTR_W'(1);
        count_q[q] <= count_q[q] + CNT_W'(push[q]) - CNT_W'(pop[q]);
      end
      if (ovf_set) err_ovf_q <= 1'b1;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] hwm_q   [2];
  logic [15:0]      stall_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        hwm_q[q]   <= '0;
        stall_q[q] <= '0;
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (count_q[q] > hwm_q[q]) hwm_q[q] <= count_q[q];
        if (valid[q] && !rdy[q] && stall_q[q] != 16'hFFFF) stall_q[q] <= stall_q[q] + 16'd1;
      end
    end
  end

  assign hwm1   = hwm_q[0];
  assign hwm2   = hwm_q[1];
  assign stall1 = stall_q[0];
  assign stall2 = stall_q[1];
`endif

  assign fifo1_full  = full[0];
  assign fifo2_full  = full[1];
  assign lane1_valid = valid[0];
  assign lane2_valid = valid[1];
  assign lane1_instr = head[0];
  assign lane2_instr = head[1];
  assign fifo1_count = count_q[0];
  assign fifo2_count = count_q[1];
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_instr_fifo_dispatch.sv
// Bench for instr_fifo_dispatch: queue-based reference model checked on every falling edge,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_instr_fifo_dispatch;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] instr_in = '0;
  logic             fifo1_en = 1'b0, fifo2_en = 1'b0;
  logic             lane1_ready = 1'b0, lane2_ready = 1'b0;
  logic             fifo1_full, fifo2_full, lane1_valid, lane2_valid, err_ovf;
  logic [WIDTH-1:0] lane1_instr, lane2_instr;
  logic [CNT_W-1:0] fifo1_count, fifo2_count;
`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] hwm1, hwm2;
  logic [15:0]      stall1, stall2;
`endif

  instr_fifo_dispatch #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .fifo1_en(fifo1_en), .fifo2_en(fifo2_en),
    .fifo1_full(fifo1_full), .fifo2_full(fifo2_full),
    .lane1_instr(lane1_instr), .lane1_valid(lane1_valid), .lane1_ready(lane1_ready),
    .lane2_instr(lane2_instr), .lane2_valid(lane2_valid), .lane2_ready(lane2_ready),
    .fifo1_count(fifo1_count), .fifo2_count(fifo2_count),
`ifdef DISPATCH_STATS_EN
    .hwm1(hwm1), .hwm2(hwm2), .stall1(stall1), .stall2(stall2),
`endif
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain queues plus a sticky error flag and statistics.
  logic [WIDTH-1:0] mq1[$], mq2[$];
  bit               m_err;
  int               m_hwm[2];
  int               m_stall[2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] head_of(input int sz, input logic [WIDTH-1:0] h);
    return (sz > 0) ? h : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("lane1_valid", 32'(lane1_valid), 32'(mq1.size() > 0));
      chk("lane2_valid", 32'(lane2_valid), 32'(mq2.size() > 0));
      chk("lane1_instr", lane1_instr, (mq1.size() > 0) ? mq1[0] : 32'h0);
      chk("lane2_instr", lane2_instr, (mq2.size() > 0) ? mq2[0] : 32'h0);
      chk("fifo1_count", 32'(fifo1_count), 32'(mq1.size()));
      chk("fifo2_count", 32'(fifo2_count), 32'(mq2.size()));
      chk("fifo1_full", 32'(fifo1_full), 32'(mq1.size() == DEPTH));
      chk("fifo2_full", 32'(fifo2_full), 32'(mq2.size() == DEPTH));
      chk("err_ovf", 32'(err_ovf), 32'(m_err));
`ifdef DISPATCH_STATS_EN
      chk("hwm1", 32'(hwm1), 32'(m_hwm[0]));
      chk("hwm2", 32'(hwm2), 32'(m_hwm[1]));
      chk("stall1", 32'(stall1), 32'(m_stall[0]));
      chk("stall2", 32'(stall2), 32'(m_stall[1]));
`endif
    end
  end

  // One clock cycle: drive inputs, take the edge, advance the model from pre-edge state.
  task automatic cycle(input bit e1, input bit e2, input bit r1, input bit r2,
                       input logic [WIDTH-1:0] d);
    int  s1, s2;
    bit  p1, p2, o1, o2;
    fifo1_en = e1; fifo2_en = e2; lane1_ready = r1; lane2_ready = r2; instr_in = d;
    @(posedge clk);
    s1 = mq1.size(); s2 = mq2.size();
    if (s1 > m_hwm[0]) m_hwm[0] = s1;
    if (s2 > m_hwm[1]) m_hwm[1] = s2;
    if (s1 > 0 && !r1 && m_stall[0] < 65535) m_stall[0]++;
    if (s2 > 0 && !r2 && m_stall[1] < 65535) m_stall[1]++;
    p1 = e1 && !e2 && s1 < DEPTH;
    p2 = e2 && !e1 && s2 < DEPTH;
    if ((e1 && e2) || (e1 && s1 == DEPTH) || (e2 && s2 == DEPTH)) m_err = 1'b1;
    o1 = r1 && s1 > 0;
    o2 = r2 && s2 > 0;
    if (o1) void'(mq1.pop_front());
    if (o2) void'(mq2.pop_front());
    if (p1) mq1.push_back(d);
    if (p2) mq2.push_back(d);
    #1;
  endtask

  // Asserted between edges so the checks below prove the clear is asynchronous.
  task automatic do_reset();
    rst = 1'b1;
    mq1.delete(); mq2.delete();
    m_err = 1'b0; m_hwm = '{0, 0}; m_stall = '{0, 0};
    #1;
    chk("rst lane1_valid", 32'(lane1_valid), 32'h0);
    chk("rst lane2_valid", 32'(lane2_valid), 32'h0);
    chk("rst fifo1_count", 32'(fifo1_count), 32'h0);
    chk("rst fifo2_count", 32'(fifo2_count), 32'h0);
    chk("rst fifo1_full", 32'(fifo1_full), 32'h0);
    chk("rst lane1_instr", lane1_instr, 32'h0);
    chk("rst err_ovf", 32'(err_ovf), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] burst[4];

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single push appears on lane 1 one cycle later; lane 2 untouched.
    cycle(1, 0, 1, 0, 32'h00045678);
    chk("t1 lane1_valid", 32'(lane1_valid), 32'h1);
    chk("t1 lane1_instr", lane1_instr, 32'h00045678);
    chk("t1 lane2_valid", 32'(lane2_valid), 32'h0);
    cycle(0, 0, 1, 0, '0);

    // Fill FIFO1 while stalled, overflow once, then drain in order.
    burst = '{32'h0005678a, 32'h000678ab, 32'h00078abc, 32'h0008abcd};
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, burst[i]);
    chk("t2 fifo1_full", 32'(fifo1_full), 32'h1);
    chk("t2 fifo1_count", 32'(fifo1_count), 32'h4);
    cycle(1, 0, 1, 0, 32'h000abcde);
    chk("t2 err_ovf", 32'(err_ovf), 32'h1);
    chk("t2 head after pop", lane1_instr, 32'h000678ab);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, '0);
    chk("t2 drained", 32'(lane1_valid), 32'h0);

    // FIFO2 held at two entries with concurrent push and pop; pointers wrap.
    cycle(0, 1, 0, 0, 32'h20000001);
    cycle(0, 1, 0, 0, 32'h20000002);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 32'h20000003 + 32'(i));
    chk("t3 fifo2_count", 32'(fifo2_count), 32'h2);
    chk("t3 lane2_instr", lane2_instr, 32'h20000007);

    // Both enables: nothing written, error set.
    do_reset();
    cycle(0, 1, 0, 0, 32'h20000010);
    cycle(1, 1, 0, 0, 32'h18000001);
    chk("t4 fifo1_count", 32'(fifo1_count), 32'h0);
    chk("t4 fifo2_count", 32'(fifo2_count), 32'h1);
    chk("t4 err_ovf", 32'(err_ovf), 32'h1);

    // Mid-stream reset discards everything; first later push is the head.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 32'h51000000 + 32'(i));
      cycle(0, 1, 0, 0, 32'h52000000 + 32'(i));
    end
    do_reset();
    cycle(1, 0, 0, 0, 32'h5a5a0001);
    chk("t5 head after reset", lane1_instr, 32'h5a5a0001);
    chk("t5 count after reset", 32'(fifo1_count), 32'h1);

`ifdef DISPATCH_STATS_EN
    do_reset();
    cycle(0, 1, 0, 0, 32'h60000001);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, '0);
    chk("t6 stall2", 32'(stall2), 32'd10);
    cycle(0, 1, 0, 0, 32'h60000002);
    cycle(0, 1, 0, 0, 32'h60000003);
    cycle(0, 0, 0, 0, '0);
    chk("t6 hwm2", 32'(hwm2), 32'd3);
`endif

    // Randomized soak: mostly legal traffic with occasional dual enables.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int  sel;
      bit  e1, e2;
      sel = int'($urandom_range(0, 19));
      e1 = (sel < 8) || (sel == 19);
      e2 = (sel >= 8 && sel < 16) || (sel == 19);
      cycle(e1, e2, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), $urandom);
      if (i == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
